// File: rtl/pe_weight_loader_pkg.sv
// pe_weight_loader_pkg: shared fixed-point types and loader FSM states
package pe_weight_loader_pkg;
   localparam int DATA_W = 16;
   localparam int FRAC_W = 8;
   typedef logic signed [DATA_W-1:0] fixed_t;
   typedef enum logic [1:0] {WL_IDLE, WL_LOAD, WL_ARM, WL_SWITCH} wl_state_t;
endpackage

// File: rtl/pe_weight_loader.sv
// pe_weight_loader: streams one weight per row into PE shadow registers, then pulses switch
module pe_weight_loader
   import pe_weight_loader_pkg::*;
#(
   parameter int ROWS   = 2,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wl_start_in,
   input  logic              wl_w_valid_in,
   input  logic [DATA_W-1:0] wl_w_data_in,
   output logic              wl_w_ready_out,
   input  logic              wl_switch_allow_in,
   output logic [ROWS-1:0]   wl_accept_w_out,
   output logic [DATA_W-1:0] wl_weight_out,
   output logic              wl_switch_out,
   output logic              wl_busy_out,
   output logic              wl_done_out
);
   localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);
   wl_state_t     state_q, state_d;
   logic [CW-1:0] row_q;
   logic          beat, last_beat;
   assign beat      = (state_q == WL_LOAD) && wl_w_valid_in;
   assign last_beat = beat && (row_q == LAST_ROW);
   always_comb begin
      state_d = state_q;
      case (state_q)
         WL_IDLE:   state_d = wl_start_in ? WL_LOAD : WL_IDLE;
         WL_LOAD:   state_d = last_beat ? WL_ARM : WL_LOAD;
         WL_ARM:    state_d = wl_switch_allow_in ? WL_SWITCH : WL_ARM;
         WL_SWITCH: state_d = WL_IDLE;
         default:   state_d = WL_IDLE;
      endcase
   end
   // Strobes and broadcast weight are registered so a beat reaches the PEs one cycle after acceptance
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= WL_IDLE;
         row_q           <= '0;
         wl_accept_w_out <= '0;
         wl_weight_out   <= '0;
      end else begin
         state_q         <= state_d;
         row_q           <= (state_q == WL_IDLE) ? '0 : (beat && !last_beat) ? row_q + 1'b1 : row_q;
         wl_accept_w_out <= beat ? ROWS'(1) << row_q : '0;
         wl_weight_out   <= beat ? wl_w_data_in : wl_weight_out;
      end
   end
   assign wl_w_ready_out = (state_q == WL_LOAD);
   assign wl_busy_out    = (state_q != WL_IDLE);
   assign wl_switch_out  = (state_q == WL_SWITCH);
   assign wl_done_out    = (state_q == WL_SWITCH);
endmodule

// File: tb/tb_pe_weight_loader.sv
// tb_pe_weight_loader: directed vectors against a 2-row column with a behavioural PE model
module tb_pe_weight_loader;
   logic        clk = 1'b0;
   logic        rst, start, valid, allow;
   logic [15:0] data;
   logic        ready, sw, busy, done;
   logic [1:0]  acc;
   logic [15:0] weight;
   logic [15:0] inactive [2] = '{16'h0, 16'h0};
   logic [15:0] active   [2] = '{16'h0, 16'h0};
   int          vecs = 0;
   int          errs = 0;
   logic [21:0] obs;
   assign obs = {busy, ready, sw, done, acc, weight};

   pe_weight_loader #(.ROWS(2), .DATA_W(16)) dut (
      .clk(clk), .rst(rst), .wl_start_in(start), .wl_w_valid_in(valid), .wl_w_data_in(data),
      .wl_w_ready_out(ready), .wl_switch_allow_in(allow), .wl_accept_w_out(acc),
      .wl_weight_out(weight), .wl_switch_out(sw), .wl_busy_out(busy), .wl_done_out(done)
   );

   always #5 clk = ~clk;

   // Downstream PEs latch on the strobe, promote on switch
   always @(negedge clk) begin
      for (int r = 0; r < 2; r++) if (acc[r]) inactive[r] <= weight;
      if (sw) begin
         active[0] <= inactive[0];
         active[1] <= inactive[1];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1; start = 0; valid = 1; allow = 1; data = 16'hABCD;
      step(); step();
      vecs++; if (obs !== 22'h0) begin errs++; $display("FAIL reset obs=%h exp=%h", obs, 22'h0); end
      rst = 0; valid = 0;
      step();
      vecs++; if (obs !== 22'h0) begin errs++; $display("FAIL reset_idle obs=%h exp=%h", obs, 22'h0); end
   endtask

   task automatic test_load();
      allow = 1; start = 1;
      step();
      vecs++; if (obs !== {4'b1100, 2'b00, 16'h0000}) begin errs++; $display("FAIL load_enter obs=%h", obs); end
      start = 0; valid = 1; data = 16'h4500;
      step();
      vecs++; if (obs !== {4'b1100, 2'b01, 16'h4500}) begin errs++; $display("FAIL load_beat0 obs=%h exp=%h", obs, {4'b1100, 2'b01, 16'h4500}); end
      data = 16'h0A00;
      step();
      vecs++; if (obs !== {4'b1000, 2'b10, 16'h0A00}) begin errs++; $display("FAIL load_beat1 obs=%h exp=%h", obs, {4'b1000, 2'b10, 16'h0A00}); end
      valid = 0;
      step();
      vecs++; if (obs !== {4'b1011, 2'b00, 16'h0A00}) begin errs++; $display("FAIL load_switch obs=%h exp=%h", obs, {4'b1011, 2'b00, 16'h0A00}); end
      step();
      vecs++; if (obs !== {4'b0000, 2'b00, 16'h0A00}) begin errs++; $display("FAIL load_idle obs=%h exp=%h", obs, {4'b0000, 2'b00, 16'h0A00}); end
      vecs++; if ({active[0], active[1]} !== {16'h4500, 16'h0A00}) begin errs++; $display("FAIL load_pe act0=%h act1=%h exp=4500 0a00", active[0], active[1]); end
   endtask

   task automatic test_gap();
      allow = 1; start = 1;
      step();
      start = 0; valid = 1; data = 16'hFE80;
      step();
      vecs++; if (obs !== {4'b1100, 2'b01, 16'hFE80}) begin errs++; $display("FAIL gap_beat0 obs=%h", obs); end
      valid = 0; data = 16'h1234;
      for (int i = 0; i < 2; i++) begin
         step();
         vecs++; if (obs !== {4'b1100, 2'b00, 16'hFE80}) begin errs++; $display("FAIL gap_hold%0d obs=%h exp=%h", i, obs, {4'b1100, 2'b00, 16'hFE80}); end
      end
      valid = 1; data = 16'h0200;
      step();
      vecs++; if (obs !== {4'b1000, 2'b10, 16'h0200}) begin errs++; $display("FAIL gap_beat1 obs=%h", obs); end
      valid = 0;
      step();
      vecs++; if (obs !== {4'b1011, 2'b00, 16'h0200}) begin errs++; $display("FAIL gap_switch obs=%h", obs); end
      step();
      vecs++; if ({active[0], active[1]} !== {16'hFE80, 16'h0200}) begin errs++; $display("FAIL gap_pe act0=%h act1=%h exp=fe80 0200", active[0], active[1]); end
   endtask

   task automatic test_hold_arm();
      allow = 0; start = 1;
      step();
      start = 0; valid = 1; data = 16'h1111;
      step();
      data = 16'h2222;
      step();
      valid = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         vecs++; if (obs !== {4'b1000, 2'b00, 16'h2222}) begin errs++; $display("FAIL arm_wait%0d obs=%h exp=%h", i, obs, {4'b1000, 2'b00, 16'h2222}); end
      end
      allow = 1;
      step();
      vecs++; if (obs !== {4'b1011, 2'b00, 16'h2222}) begin errs++; $display("FAIL arm_switch obs=%h", obs); end
      step();
      vecs++; if (obs !== {4'b0000, 2'b00, 16'h2222}) begin errs++; $display("FAIL arm_once obs=%h", obs); end
      vecs++; if ({active[0], active[1]} !== {16'h1111, 16'h2222}) begin errs++; $display("FAIL arm_pe act0=%h act1=%h exp=1111 2222", active[0], active[1]); end
   endtask

   task automatic test_rst_mid();
      allow = 1; start = 1;
      step();
      start = 0; valid = 1; data = 16'h7777;
      step();
      vecs++; if (acc !== 2'b01) begin errs++; $display("FAIL rst_pre acc=%b exp=01", acc); end
      rst = 1; valid = 0;
      step();
      vecs++; if (obs !== 22'h0) begin errs++; $display("FAIL rst_mid obs=%h exp=%h", obs, 22'h0); end
      rst = 0;
      step(); step();
      vecs++; if ({sw, busy, active[0], active[1]} !== {2'b00, 16'h1111, 16'h2222}) begin errs++; $display("FAIL rst_noswitch sw=%b busy=%b act0=%h act1=%h", sw, busy, active[0], active[1]); end
      start = 1;
      step();
      start = 0; valid = 1; data = 16'h0300;
      step();
      vecs++; if (obs !== {4'b1100, 2'b01, 16'h0300}) begin errs++; $display("FAIL rst_reload0 obs=%h", obs); end
      data = 16'h0400;
      step();
      valid = 0;
      step(); step();
      vecs++; if ({active[0], active[1]} !== {16'h0300, 16'h0400}) begin errs++; $display("FAIL rst_reload_pe act0=%h act1=%h exp=0300 0400", active[0], active[1]); end
   endtask

   task automatic test_ignore();
      valid = 1; data = 16'h5555; start = 0; allow = 1;
      for (int i = 0; i < 2; i++) begin
         step();
         vecs++; if (obs !== {4'b0000, 2'b00, 16'h0400}) begin errs++; $display("FAIL idle_valid%0d obs=%h exp=%h", i, obs, {4'b0000, 2'b00, 16'h0400}); end
      end
      valid = 0; start = 1;
      step();
      valid = 1; data = 16'h0101;
      step();
      vecs++; if (obs !== {4'b1100, 2'b01, 16'h0101}) begin errs++; $display("FAIL busy_start0 obs=%h", obs); end
      data = 16'h0202; allow = 0;
      step();
      valid = 0;
      step();
      vecs++; if (obs !== {4'b1000, 2'b00, 16'h0202}) begin errs++; $display("FAIL busy_start_arm obs=%h", obs); end
      allow = 1;
      step();
      vecs++; if (obs !== {4'b1011, 2'b00, 16'h0202}) begin errs++; $display("FAIL busy_start_sw obs=%h", obs); end
      step();
      vecs++; if (obs !== {4'b0000, 2'b00, 16'h0202}) begin errs++; $display("FAIL switch_start obs=%h", obs); end
      start = 0;
      step();
   endtask

   initial begin
      test_reset();
      test_load();
      test_gap();
      test_hold_arm();
      test_rst_mid();
      test_ignore();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
